// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues word fetches to imem, buffers responses
// in a small prefetch FIFO and hands them to the decoder with redirect support.
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_pc,
    input  logic [CNT_WIDTH-1:0]  instr_count,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [31:0]           imem_rsp_data,
    output logic [31:0]           instruction,
    output logic                  valid,
    input  logic                  ready,
    output logic                  busy,
    output logic                  done
);

    localparam int IW = $clog2(FIFO_DEPTH);
    localparam int PW = IW + 1;
    localparam int SW = PW + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_WIDTH-1:0]  rem_q, rem_d;
    logic [PW-1:0]         live_q, live_d;
    logic [PW-1:0]         stale_q, stale_d;
    logic [PW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         rd_q, rd_d;
    logic [IW-1:0]         wr_q, wr_d;
    logic [31:0]           mem_q [FIFO_DEPTH];
    logic [31:0]           mem_d [FIFO_DEPTH];

    logic [SW-1:0] in_flight;
    logic [SW-1:0] occupied;
    logic          do_flush;
    logic          req_ok;
    logic          fire;
    logic          rsp_live;
    logic          push;
    logic          pop;

    assign valid          = cnt_q != '0;
    assign instruction    = valid ? mem_q[rd_q] : 32'd0;
    assign busy           = state_q != S_IDLE;
    assign done           = state_q == S_FINISH;
    assign imem_req_addr  = pc_q;
    assign imem_req_valid = req_ok;

    always_comb begin
        in_flight = SW'(cnt_q) + SW'(live_q);
        occupied  = in_flight + SW'(stale_q);
        do_flush  = flush && (state_q == S_FETCH);
        // Never ask for more words than the run still needs or the FIFO can hold.
        req_ok    = (state_q == S_FETCH) && !flush
                    && (rem_q > CNT_WIDTH'(in_flight))
                    && (occupied < SW'(FIFO_DEPTH));
        fire      = req_ok && imem_req_ready;
        rsp_live  = imem_rsp_valid && (stale_q == '0);
        push      = rsp_live && !do_flush;
        pop       = valid && ready;

        state_d = state_q;
        pc_d    = pc_q;
        rem_d   = rem_q;
        live_d  = live_q;
        stale_d = stale_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        mem_d   = mem_q;

        if (do_flush) begin
            stale_d = stale_q + live_q - PW'(imem_rsp_valid);
            live_d  = '0;
        end else begin
            stale_d = stale_q - PW'(imem_rsp_valid && !rsp_live);
            live_d  = live_q + PW'(fire) - PW'(rsp_live);
        end

        if (push) begin
            mem_d[wr_q] = imem_rsp_data;
        end
        if (do_flush) begin
            cnt_d = '0;
            rd_d  = '0;
            wr_d  = '0;
        end else begin
            cnt_d = cnt_q + PW'(push) - PW'(pop);
            rd_d  = rd_q + IW'(pop);
            wr_d  = wr_q + IW'(push);
        end

        if (pop) begin
            rem_d = rem_q - 1'b1;
        end
        if (fire) begin
            pc_d = pc_q + ADDR_WIDTH'(4);
        end
        if (do_flush) begin
            pc_d = flush_pc;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = start_pc;
                    rem_d   = instr_count;
                    state_d = (instr_count == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                if (rem_d == '0) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            rem_q   <= '0;
            live_q  <= '0;
            stale_q <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rem_q   <= rem_d;
            live_q  <= live_d;
            stale_q <= stale_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit with a queue-based
// reference model of memory, prefetch buffer and run bookkeeping.
module tb_instruction_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] start_pc;
    logic [15:0] instr_count;
    logic        flush;
    logic [31:0] flush_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instruction;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .start_pc       (start_pc),
        .instr_count    (instr_count),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instruction    (instruction),
        .valid          (valid),
        .ready          (ready),
        .busy           (busy),
        .done           (done)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef enum {M_IDLE, M_FETCH, M_FIN} mst_t;

    req_t        mq[$];
    logic [31:0] fq[$];
    mst_t        mst = M_IDLE;
    int          m_rem = 0;
    int          m_epoch = 0;
    logic [31:0] m_req_addr = 32'd0;
    int          cyc = 0;

    int n_checks = 0;
    int n_errors = 0;

    int k_ready, k_rr, k_rsp, k_flush, k_lat_lo, k_lat_hi;
    logic        start_now = 1'b0;
    logic        flush_now = 1'b0;
    logic [31:0] start_pc_v, fpc_v;
    logic [15:0] cnt_v;
    int fires_run, deliv_run, dones_run;
    int done_cyc, last_dlv_cyc, start_cyc;
    logic [31:0] last_fire_addr;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16]} + 32'h1357_9BDF;
    endfunction

    function automatic int cnt_live();
        int n = 0;
        foreach (mq[i]) if (mq[i].epoch == m_epoch) n++;
        return n;
    endfunction

    task automatic cycle();
        int   live, stale, lat;
        logic rsp, flush_eff, exp_rv, fire, dlv;
        req_t e;
        @(posedge clk);
        #1;
        cyc++;
        chk("busy", busy, mst != M_IDLE);
        chk("done", done, mst == M_FIN);
        chk("valid", valid, fq.size() != 0);
        chk("instr", instruction, fq.size() != 0 ? fq[0] : 32'd0);
        if (done) begin
            dones_run++;
            done_cyc = cyc;
        end
        ready          = $urandom_range(99) < k_ready;
        imem_req_ready = $urandom_range(99) < k_rr;
        rsp = mq.size() != 0 && mq[0].due <= cyc
              && $urandom_range(99) < k_rsp;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mq[0].addr) : $urandom;
        start       = start_now;
        start_pc    = start_pc_v;
        instr_count = cnt_v;
        flush       = flush_now || ($urandom_range(99) < k_flush);
        if (flush_now) flush_pc = fpc_v;
        else flush_pc = $urandom & 32'hFFFF_FFFC;
        start_now = 1'b0;
        flush_now = 1'b0;
        #1;
        live  = cnt_live();
        stale = mq.size() - live;
        flush_eff = flush && mst == M_FETCH;
        exp_rv = mst == M_FETCH && !flush_eff
                 && m_rem > fq.size() + live
                 && fq.size() + live + stale < DEPTH;
        chk("req_valid", imem_req_valid, exp_rv);
        fire = exp_rv && imem_req_ready;
        if (fire) chk("req_addr", imem_req_addr, m_req_addr);
        dlv = fq.size() != 0 && ready;
        if (dlv) begin
            void'(fq.pop_front());
            m_rem--;
            deliv_run++;
            last_dlv_cyc = cyc;
        end
        if (rsp) begin
            e = mq.pop_front();
            if (!flush_eff && e.epoch == m_epoch) fq.push_back(mem_word(e.addr));
        end
        if (flush_eff) begin
            fq.delete();
            m_epoch++;
            m_req_addr = flush_pc;
        end
        if (fire) begin
            lat = $urandom_range(k_lat_hi, k_lat_lo);
            mq.push_back('{addr: m_req_addr, epoch: m_epoch, due: cyc + lat});
            last_fire_addr = m_req_addr;
            m_req_addr += 32'd4;
            fires_run++;
        end
        case (mst)
            M_IDLE: if (start) begin
                m_req_addr = start_pc;
                m_rem      = int'(instr_count);
                start_cyc  = cyc;
                mst        = (instr_count == 16'd0) ? M_FIN : M_FETCH;
            end
            M_FETCH: if (m_rem == 0) mst = M_FIN;
            default: mst = M_IDLE;
        endcase
    endtask

    task automatic start_run(logic [31:0] pc, int n);
        start_pc_v = pc;
        cnt_v      = 16'(n);
        start_now  = 1'b1;
        fires_run  = 0;
        deliv_run  = 0;
        dones_run  = 0;
        cycle();
    endtask

    task automatic finish_run(int n, int budget);
        for (int i = 0; i < budget && mst != M_IDLE; i++) cycle();
        chk("run_end", mst == M_IDLE, 1'b1);
        chk("deliveries", deliv_run, n);
        chk("done_pulses", dones_run, 1);
        if (n > 0) chk("done_lat", done_cyc - last_dlv_cyc, 1);
    endtask

    task automatic set_knobs(int r, int rr, int rs, int fl, int lo, int hi);
        k_ready = r; k_rr = rr; k_rsp = rs;
        k_flush = fl; k_lat_lo = lo; k_lat_hi = hi;
    endtask

    task automatic quiet_inputs();
        start = 1'b0; flush = 1'b0; ready = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'd0; start_pc = 32'd0;
        instr_count = 16'd0; flush_pc = 32'd0;
    endtask

    task automatic check_reset_outs(string tag);
        chk({tag, "_reqv"}, imem_req_valid, 1'b0);
        chk({tag, "_addr"}, imem_req_addr, 32'd0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_valid"}, valid, 1'b0);
        chk({tag, "_instr"}, instruction, 32'd0);
    endtask

    initial begin
        int ok, n;
        logic [31:0] pc;
        rst_n = 1'b0;
        quiet_inputs();
        set_knobs(100, 100, 100, 0, 1, 1);
        start_pc_v = 0; cnt_v = 0; fpc_v = 0;
        #3;
        check_reset_outs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 3-word run, everything ready, 1-cycle latency
        start_run(32'h100, 3);
        finish_run(3, 40);
        chk("t1_fires", fires_run, 3);

        // decoder stalled: only DEPTH words may be fetched
        set_knobs(0, 100, 100, 0, 1, 1);
        start_run(32'h100, 8);
        repeat (20) cycle();
        chk("bp_fires", fires_run, 4);
        chk("bp_deliv", deliv_run, 0);
        k_ready = 100;
        finish_run(8, 100);
        chk("bp_fires_all", fires_run, 8);

        // flush with 2 queued and 2 outstanding
        set_knobs(0, 100, 100, 0, 3, 3);
        start_run(32'h100, 10);
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (fq.size() == 2 && cnt_live() == 2) ok = 1;
            else cycle();
        end
        chk("flush_setup", ok, 1);
        fpc_v = 32'h200;
        flush_now = 1'b1;
        n = fires_run;
        cycle();
        for (int i = 0; i < 30 && fires_run == n; i++) cycle();
        chk("flush_next_addr", last_fire_addr, 32'h200);
        k_ready = 100;
        finish_run(10, 200);

        // empty run
        set_knobs(100, 100, 100, 0, 1, 1);
        start_run(32'h300, 0);
        finish_run(0, 10);
        chk("zero_fires", fires_run, 0);
        chk("zero_done_lat", done_cyc - start_cyc, 1);

        // flush coinciding with a delivery
        start_run(32'h400, 6);
        for (int i = 0; i < 20 && fq.size() == 0; i++) cycle();
        chk("fd_setup", fq.size() != 0, 1'b1);
        fpc_v = 32'h500;
        flush_now = 1'b1;
        n = deliv_run;
        cycle();
        chk("fd_counted", deliv_run, n + 1);
        finish_run(6, 100);

        // start while busy is ignored
        start_run(32'h600, 5);
        cycle();
        start_pc_v = 32'h700;
        cnt_v = 16'd9;
        start_now = 1'b1;
        cycle();
        finish_run(5, 100);

        // address wrap
        start_run(32'hFFFF_FFF8, 4);
        finish_run(4, 50);

        // asynchronous reset mid-run
        set_knobs(50, 100, 100, 0, 1, 2);
        start_run(32'h800, 12);
        repeat (5) cycle();
        #2;
        rst_n = 1'b0;
        quiet_inputs();
        #1;
        check_reset_outs("midrst");
        mq.delete();
        fq.delete();
        mst = M_IDLE;
        m_rem = 0;
        m_req_addr = 32'd0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("midrst_no_done", done, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_knobs(100, 100, 100, 0, 1, 1);
        start_run(32'h900, 5);
        finish_run(5, 60);

        // random runs
        for (int r = 0; r < 14; r++) begin
            set_knobs($urandom_range(100, 20), $urandom_range(100, 30),
                      $urandom_range(100, 40), $urandom_range(8, 0),
                      1, $urandom_range(4, 1));
            n  = $urandom_range(24, 0);
            pc = $urandom & 32'hFFFF_FFFC;
            start_run(pc, n);
            finish_run(n, 3000);
            repeat ($urandom_range(3, 0)) cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
